program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Byte-stream instruction loader; drives the processor's instruction-init port
//  (initialize_instructions, ram_init_wadrs, ram_write_instruction).
//  Assembles bytes little-endian into DATA_WIDTH words and writes them to
//  sequential RAM addresses from 0, with the init port held high for the session.
//  Drops init when the load completes, releasing the processor from WRITE to FETCH.
// PARAMETERS
//  DATA_WIDTH     32  instruction word width; must be a multiple of 8 (BPW = DATA_WIDTH/8)
//  ADDRESS_WIDTH  12  RAM address width; capacity 2**ADDRESS_WIDTH words
// PORTS
//  clk                    in   1              clock; all logic on posedge
//  reset                  in   1              synchronous, active-high
//  start                  in   1              begin load session (sampled in IDLE only)
//  s_valid                in   1              byte stream valid
//  s_data                 in   8              byte stream data
//  s_last                 in   1              qualifies final byte of program
//  s_ready                out  1              byte accepted when s_valid & s_ready
//  initialize_instructions out 1              high for whole session (PRIME..DRAIN)
//  ram_init_wadrs         out  ADDRESS_WIDTH  RAM write address
//  ram_write_instruction  out  DATA_WIDTH     RAM write data
//  load_done              out  1              1-cycle pulse in DONE
//  word_count             out  ADDRESS_WIDTH+1 words committed this session; held until next start
//  err_overflow           out  1              sticky: bytes arrived past last address
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, byte index 0, word index 0, assembly reg 0.
//   Reset mid-session aborts immediately; init drops the next cycle, no partial commit.
//  States:
//   IDLE: s_ready=0, init=0. start -> PRIME; clear word_count, err_overflow.
//   PRIME (1 cyc): init=1, wadrs=0, wdata=0 -> COLLECT.
//    Absorbs the processor's first init cycle, in which the processor writes to an
//    undefined address.
//   COLLECT: s_ready=1, init=1. wadrs/wdata hold last driven value; rewrites are harmless.
//    Accepted byte k goes to bits [8k+7:8k].
//    On byte BPW-1, or on any byte with s_last -> COMMIT.
//   COMMIT (1 cyc): s_ready=0, init=1, wadrs=word index, wdata=assembled word.
//    Unfilled upper bytes on an s_last partial word are 0.
//    Then: word index++, word_count++, byte index=0, assembly reg=0.
//    Next state: DONE if the committed word ended on s_last.
//    Else DRAIN, set err_overflow, if word index was 2**ADDRESS_WIDTH-1.
//    Else COLLECT.
//   DRAIN: s_ready=1, init=1, wadrs/wdata held. Bytes discarded; accepted s_last -> DONE.
//   DONE (1 cyc): init=0, s_ready=0, load_done=1 -> IDLE.
//  Handshake: s_data/s_last are sampled only when s_valid&s_ready.
//   s_valid low stalls COLLECT indefinitely, with init held high.
//  start outside IDLE is ignored. s_last with zero bytes accepted is impossible
//   (s_last rides a byte).
//  Word index wraps never; the overflow path covers it. ram_init_wadrs equals
//   word index [ADDRESS_WIDTH-1:0].
//  Latency: last byte accepted -> COMMIT next cycle -> init low two cycles after
//   the last byte.
// TESTING
//  1. start; bytes 78 56 34 12, EF BE AD DE(last) -> COMMITs addr0=0x12345678,
//     addr1=0xDEADBEEF; word_count=2; load_done pulse; init low after.
//  2. start; bytes AA BB(last) -> single COMMIT addr0=0x0000BBAA; word_count=1.
//  3. s_valid toggling every other cycle during word 0 -> same commit values;
//     init stays high across stalls.
//  4. ADDRESS_WIDTH=2: 5 words + 3 extra bytes, last on the final byte ->
//     4 commits (addr 0..3), err_overflow=1, extra bytes consumed, load_done.
//  5. reset asserted mid-word-1 -> next cycle init=0, s_ready=0, state IDLE;
//     new start reloads from addr0.
//  6. start pulsed during COLLECT -> ignored; word_count and err_overflow unchanged.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream side and processor instruction-init side of the program loader.
// The loader takes the slave modport; the stream source or bench takes master.
interface program_loader_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
);
    logic                     start;
    logic                     s_valid;
    logic [7:0]               s_data;
    logic                     s_last;
    logic                     s_ready;
    logic                     initialize_instructions;
    logic [ADDRESS_WIDTH-1:0] ram_init_wadrs;
    logic [DATA_WIDTH-1:0]    ram_write_instruction;
    logic                     load_done;
    logic [ADDRESS_WIDTH:0]   word_count;
    logic                     err_overflow;

    modport master (
        output start, s_valid, s_data, s_last,
        input  s_ready, initialize_instructions, ram_init_wadrs, ram_write_instruction,
               load_done, word_count, err_overflow
    );

    modport slave (
        input  start, s_valid, s_data, s_last,
        output s_ready, initialize_instructions, ram_init_wadrs, ram_write_instruction,
               load_done, word_count, err_overflow
    );
endinterface

// File: rtl/program_loader.sv
// Byte-stream instruction loader: packs bytes little-endian into words and writes
// them to sequential RAM addresses from 0 while holding the processor in init.
module program_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic               clk,
    input  logic               reset,
    program_loader_if.slave    bus
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BIW-1:0]           LAST_IDX = BIW'(BPW - 1);
    localparam logic [ADDRESS_WIDTH-1:0] MAX_ADR  = '1;

    typedef enum logic [2:0] {IDLE, PRIME, COLLECT, COMMIT, DRAIN, DONE} state_t;

    state_t                   state;
    logic [BIW-1:0]           byte_idx;
    logic [DATA_WIDTH-1:0]    asm_word;
    logic [DATA_WIDTH-1:0]    asm_next;
    logic                     last_seen;
    logic                     s_ready;
    logic                     init;
    logic                     load_done;
    logic                     err_overflow;
    logic [ADDRESS_WIDTH-1:0] wadrs;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [ADDRESS_WIDTH:0]   word_count;   // doubles as the word index
    logic                     accept;

    assign accept = bus.s_valid & s_ready;

    always_comb begin
        asm_next = asm_word | (DATA_WIDTH'(bus.s_data) << {byte_idx, 3'b000});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_idx     <= '0;
            asm_word     <= '0;
            last_seen    <= 1'b0;
            s_ready      <= 1'b0;
            init         <= 1'b0;
            load_done    <= 1'b0;
            err_overflow <= 1'b0;
            wadrs        <= '0;
            wdata        <= '0;
            word_count   <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state        <= PRIME;
                    init         <= 1'b1;
                    wadrs        <= '0;
                    wdata        <= '0;
                    word_count   <= '0;
                    err_overflow <= 1'b0;
                end
                // The processor's first init cycle writes to an undefined address.
                PRIME: begin
                    state   <= COLLECT;
                    s_ready <= 1'b1;
                end
                COLLECT: if (accept) begin
                    asm_word <= asm_next;
                    byte_idx <= byte_idx + 1'b1;
                    if (byte_idx == LAST_IDX || bus.s_last) begin
                        state     <= COMMIT;
                        s_ready   <= 1'b0;
                        last_seen <= bus.s_last;
                        wadrs     <= word_count[ADDRESS_WIDTH-1:0];
                        wdata     <= asm_next;
                    end
                end
                COMMIT: begin
                    word_count <= word_count + 1'b1;
                    byte_idx   <= '0;
                    asm_word   <= '0;
                    if (last_seen) begin
                        state     <= DONE;
                        init      <= 1'b0;
                        load_done <= 1'b1;
                    end else if (word_count[ADDRESS_WIDTH-1:0] == MAX_ADR) begin
                        state        <= DRAIN;
                        err_overflow <= 1'b1;
                        s_ready      <= 1'b1;
                    end else begin
                        state   <= COLLECT;
                        s_ready <= 1'b1;
                    end
                end
                // RAM is full: swallow the rest of the program up to s_last.
                DRAIN: if (accept && bus.s_last) begin
                    state     <= DONE;
                    s_ready   <= 1'b0;
                    init      <= 1'b0;
                    load_done <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready                 = s_ready;
    assign bus.initialize_instructions = init;
    assign bus.ram_init_wadrs          = wadrs;
    assign bus.ram_write_instruction   = wdata;
    assign bus.load_done               = load_done;
    assign bus.word_count              = word_count;
    assign bus.err_overflow            = err_overflow;
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a byte-list model predicts word commits and
// the session result; a monitor compares them against the init port as they occur.
module tb_program_loader;
    localparam int DW  = 32;
    localparam int AW  = 2;
    localparam int BPW = DW / 8;
    localparam int CAP = 1 << AW;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} commit_t;
    typedef struct packed {logic [AW:0] wc; logic err;} done_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    program_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();
    program_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    commit_t exp_commit[$];
    done_t   exp_done[$];
    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no response within cycle budget", name);
        finish_sim();
    endtask

    // Reference: word w holds bytes w*BPW.. little-endian, zero-filled; only the
    // first CAP words fit, anything beyond flags overflow.
    task automatic model(input bq_t b, input int abort_at);
        int nwords, ncommit;
        commit_t c;
        done_t d;
        if (abort_at >= 0) begin
            nwords  = abort_at / BPW;
            ncommit = (nwords < CAP) ? nwords : CAP;
        end else begin
            nwords  = (b.size() + BPW - 1) / BPW;
            ncommit = (nwords < CAP) ? nwords : CAP;
        end
        for (int w = 0; w < ncommit; w++) begin
            c.addr = AW'(w);
            c.data = '0;
            for (int k = 0; k < BPW; k++)
                if (w * BPW + k < b.size()) c.data[8*k +: 8] = b[w*BPW + k];
            exp_commit.push_back(c);
        end
        if (abort_at < 0) begin
            d.wc  = (AW+1)'(ncommit);
            d.err = (nwords > CAP);
            exp_done.push_back(d);
        end
    endtask

    task automatic run_prog(input bq_t b, input int stall_pct, input int glitch_at, input int abort_at);
        int base, t, nwords;
        bit acc, ovf;
        model(b, abort_at);
        nwords = (b.size() + BPW - 1) / BPW;
        ovf    = (nwords > CAP);
        base   = done_seen;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            if (i == abort_at) begin
                bus.s_valid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                check("abort_init", bus.initialize_instructions, 0);
                check("abort_ready", bus.s_ready, 0);
                check("abort_wc", bus.word_count, 0);
                check("abort_pending_commits", exp_commit.size(), 0);
                reset = 1'b0;
                @(negedge clk);
                return;
            end
            while ($urandom_range(99) < stall_pct) begin
                bus.s_valid = 1'b0;
                @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = b[i];
            bus.s_last  = (i == b.size() - 1);
            if (i == glitch_at) bus.start = 1'b1;
            acc = 1'b0;
            t = 0;
            while (!acc) begin
                acc = bus.s_ready;
                @(negedge clk);
                bus.start = 1'b0;
                if (++t > 50) timeout("byte_accept");
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (!ovf) begin
            check("commit_after_last", {bus.initialize_instructions, bus.s_ready, bus.load_done}, 3'b100);
            @(negedge clk);
        end
        check("done_latency", {bus.initialize_instructions, bus.load_done}, 2'b01);
        @(negedge clk);
        check("done_seen", done_seen, base + 1);
        check("idle_outputs", {bus.initialize_instructions, bus.s_ready, bus.load_done}, 3'b000);
    endtask

    // Monitor: a commit is the only cycle where s_ready falls while init stays high.
    logic    prev_ready = 1'b0;
    commit_t mc;
    done_t   md;
    always begin
        @(posedge clk);
        #1;
        if (reset) prev_ready = 1'b0;
        else begin
            if (bus.initialize_instructions && !bus.s_ready && prev_ready) begin
                if (exp_commit.size() == 0) check("unexpected_commit", bus.ram_init_wadrs, '1);
                else begin
                    mc = exp_commit.pop_front();
                    check("commit_addr", bus.ram_init_wadrs, mc.addr);
                    check("commit_data", bus.ram_write_instruction, mc.data);
                end
            end
            if (bus.load_done) begin
                done_seen++;
                if (exp_done.size() == 0) check("unexpected_done", bus.word_count, '1);
                else begin
                    md = exp_done.pop_front();
                    check("word_count", bus.word_count, md.wc);
                    check("err_overflow", bus.err_overflow, md.err);
                end
            end
            prev_ready = bus.s_ready;
        end
    end

    initial begin
        #400000;
        timeout("watchdog");
    end

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t b;
        reset = 1'b1;
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {bus.s_ready, bus.initialize_instructions, bus.load_done,
                              bus.err_overflow, bus.ram_init_wadrs, bus.ram_write_instruction,
                              bus.word_count}, '0);
        reset = 1'b0;
        @(negedge clk);

        b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_prog(b, 0, -1, -1);
        b = '{8'hAA, 8'hBB};
        run_prog(b, 0, -1, -1);
        b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_prog(b, 50, -1, -1);
        run_prog(rand_bytes(5 * BPW + 3), 0, -1, -1);   // overflow with drained tail
        run_prog(rand_bytes(CAP * BPW), 0, -1, -1);     // exactly full: no overflow
        run_prog(rand_bytes(CAP * BPW + 1), 20, -1, -1);
        run_prog(rand_bytes(8), 0, -1, 5);              // reset mid word 1
        b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_prog(b, 0, -1, -1);
        run_prog(rand_bytes(8), 0, 2, -1);              // start during COLLECT
        run_prog(rand_bytes(CAP * BPW + 2), 0, 3, -1);  // start glitch on overflow run

        for (int r = 0; r < 25; r++)
            run_prog(rand_bytes($urandom_range(1, (CAP + 2) * BPW)), $urandom_range(0, 60),
                     ($urandom_range(3) == 0) ? $urandom_range(1, 4) : -1, -1);

        repeat (2) @(negedge clk);
        check("commit_queue_empty", exp_commit.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        finish_sim();
    end
endmodule
